// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done
// handshake. Results (bcd, overflow, digit-valid mask) are held between
// conversions so a downstream display never sees partial values.

// Per-digit shift-and-add-3 correction: a digit >= 5 gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  // add 3 to any digit of 5 or more, otherwise pass through
  always_comb adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;
endmodule

module bin_to_bcd_converter #(
  parameter int BIN_WIDTH  = 27,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o,
  output logic [NUM_DIGITS*4-1:0] bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o
);
  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CW    = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic                 accept, last_iter;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_nxt, result;
  logic [BIN_WIDTH-1:0] bin_q, bin_nxt;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q, ovf_final, shift_out;
  logic [NUM_DIGITS-1:0] valid_nxt;

  // all digits corrected in parallel before the shift
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .digit (bcd_q[4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  // one double-dabble step: shift {bcd, bin} left, binary MSB feeds BCD bit 0;
  // whatever leaves the top digit means the value no longer fits
  assign {shift_out, bcd_nxt, bin_nxt} = {bcd_adj, bin_q, 1'b0};
  assign last_iter = (cnt_q == CW'(BIN_WIDTH - 1));
  assign ovf_final = ovf_q | shift_out;
  assign result    = ovf_final ? {NUM_DIGITS{4'h9}} : bcd_nxt;
  assign busy_o    = (state_q == SHIFT);

  // leading-zero mask: bit k set once any digit at k or above is nonzero
  always_comb begin
    logic acc;
    acc       = 1'b0;
    valid_nxt = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc          = acc | (|result[4*k +: 4]);
      valid_nxt[k] = acc;
    end
    valid_nxt[0] = 1'b1;
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: accept in IDLE, leave SHIFT after the final iteration
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // working register, iteration counter and held result outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_q         <= '0;
      bin_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      done_o        <= 1'b0;
      overflow_o    <= 1'b0;
      bcd_o         <= '0;
      digit_valid_o <= NUM_DIGITS'(1);
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        bin_q <= bin_i;
        bcd_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        bcd_q <= bcd_nxt;
        bin_q <= bin_nxt;
        cnt_q <= cnt_q + CW'(1);
        ovf_q <= ovf_final;
        if (last_iter) begin
          bcd_o         <= result;
          overflow_o    <= ovf_final;
          digit_valid_o <= valid_nxt;
          done_o        <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed and random checks for bin_to_bcd_converter (27-bit in, 8 digits).
module tb_bin_to_bcd_converter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic        busy, done, ovf;
  logic [31:0] bcd;
  logic [7:0]  dv;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(27), .NUM_DIGITS(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
    .busy_o(busy), .done_o(done), .overflow_o(ovf),
    .bcd_o(bcd), .digit_valid_o(dv)
  );

  always #5 clk = ~clk;

  // Starts a conversion from the current negedge and waits for done.
  // cyc counts negedges until done is seen (28 = done 27 cycles after the
  // accepting edge). Optionally re-pulses start mid-conversion.
  task automatic conv(input logic [26:0] b, input int poke_cyc,
                      input logic [26:0] poke_bin, output int cyc,
                      output int busy_cnt, output int chg);
    logic [31:0] held;
    held = bcd;
    cyc = 0; busy_cnt = 0; chg = 0;
    start = 1'b1; bin = b;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == poke_cyc) begin start = 1'b1; bin = poke_bin; end
      if (cyc == poke_cyc + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (!done && bcd !== held) chg++;
    end while (!done && cyc < 60);
  endtask

  function automatic logic [31:0] ref_bcd(input logic [26:0] v);
    logic [31:0] r;
    int x;
    x = int'(v);
    if (x > 99999999) return 32'h99999999;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_dv(input logic [31:0] v);
    logic [7:0] m;
    logic acc;
    acc = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      acc = acc | (v[4*k +: 4] != 4'h0);
      m[k] = acc;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (bcd !== 32'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=00000000", bcd); end
    total++; if (dv !== 8'h01) begin bad++; $display("FAIL reset_dv got=%h exp=01", dv); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc, bc, chg;
    conv(27'd0, -5, 27'd0, cyc, bc, chg);
    total++; if (cyc !== 28) begin bad++; $display("FAIL zero_latency got=%0d exp=28", cyc); end
    total++; if (bcd !== 32'h0) begin bad++; $display("FAIL zero_bcd got=%h exp=00000000", bcd); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
    total++; if (dv !== 8'h01) begin bad++; $display("FAIL zero_dv got=%h exp=01", dv); end
  endtask

  task automatic test_values();
    int cyc, bc, chg;
    conv(27'd12345678, -5, 27'd0, cyc, bc, chg);
    total++; if (bcd !== 32'h12345678) begin bad++; $display("FAIL val_bcd_a got=%h exp=12345678", bcd); end
    total++; if (dv !== 8'hFF) begin bad++; $display("FAIL val_dv_a got=%h exp=ff", dv); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL val_ovf_a got=%b exp=0", ovf); end
    conv(27'd1000, -5, 27'd0, cyc, bc, chg);
    total++; if (bcd !== 32'h00001000) begin bad++; $display("FAIL val_bcd_b got=%h exp=00001000", bcd); end
    total++; if (dv !== 8'h0F) begin bad++; $display("FAIL val_dv_b got=%h exp=0f", dv); end
  endtask

  task automatic test_overflow();
    int cyc, bc, chg;
    conv(27'd99999999, -5, 27'd0, cyc, bc, chg);
    total++; if (bcd !== 32'h99999999) begin bad++; $display("FAIL max_bcd got=%h exp=99999999", bcd); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b exp=0", ovf); end
    conv(27'd100000000, -5, 27'd0, cyc, bc, chg);
    total++; if (bcd !== 32'h99999999) begin bad++; $display("FAIL ovf1_bcd got=%h exp=99999999", bcd); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf1_ovf got=%b exp=1", ovf); end
    conv(27'h7FFFFFF, -5, 27'd0, cyc, bc, chg);
    total++; if (bcd !== 32'h99999999) begin bad++; $display("FAIL ovf2_bcd got=%h exp=99999999", bcd); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf2_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc, chg;
    conv(27'd42, 5, 27'd7, cyc, bc, chg);
    total++; if (cyc !== 28) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=28", cyc); end
    total++; if (bc !== 27) begin bad++; $display("FAIL busy_len got=%0d exp=27", bc); end
    total++; if (bcd !== 32'h00000042) begin bad++; $display("FAIL busy_ignore_bcd got=%h exp=00000042", bcd); end
    // start during the done cycle
    conv(27'd7, -5, 27'd0, cyc, bc, chg);
    total++; if (cyc !== 28) begin bad++; $display("FAIL b2b_spacing got=%0d exp=28", cyc); end
    total++; if (bcd !== 32'h00000007) begin bad++; $display("FAIL b2b_bcd got=%h exp=00000007", bcd); end
    total++; if (dv !== 8'h01) begin bad++; $display("FAIL b2b_dv got=%h exp=01", dv); end
  endtask

  task automatic test_reset_abort();
    int cyc, bc, chg, dones;
    @(negedge clk);
    start = 1'b1; bin = 27'd12345678;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (bcd !== 32'h0) begin bad++; $display("FAIL abort_bcd got=%h exp=00000000", bcd); end
    total++; if (dv !== 8'h01) begin bad++; $display("FAIL abort_dv got=%h exp=01", dv); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    conv(27'd12345678, -5, 27'd0, cyc, bc, chg);
    total++; if (cyc !== 28) begin bad++; $display("FAIL post_reset_latency got=%0d exp=28", cyc); end
    total++; if (bcd !== 32'h12345678) begin bad++; $display("FAIL post_reset_bcd got=%h exp=12345678", bcd); end
  endtask

  task automatic test_random();
    int cyc, bc, chg;
    logic [26:0] v;
    logic [31:0] e;
    for (int i = 0; i < 1000; i++) begin
      v = 27'($urandom());
      e = ref_bcd(v);
      conv(v, -5, 27'd0, cyc, bc, chg);
      total++; if (cyc !== 28) begin bad++; $display("FAIL rnd_latency v=%0d got=%0d exp=28", v, cyc); end
      total++; if (bcd !== e) begin bad++; $display("FAIL rnd_bcd v=%0d got=%h exp=%h", v, bcd, e); end
      total++; if (ovf !== (v > 27'd99999999)) begin bad++; $display("FAIL rnd_ovf v=%0d got=%b exp=%b", v, ovf, v > 27'd99999999); end
      total++; if (dv !== ref_dv(e)) begin bad++; $display("FAIL rnd_dv v=%0d got=%h exp=%h", v, dv, ref_dv(e)); end
      total++; if (chg !== 0) begin bad++; $display("FAIL rnd_stable v=%0d got=%0d changes exp=0", v, chg); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble (shift-and-add-3) converter from unsigned binary to packed BCD.
- Sits directly upstream of the multiplexed seven-segment display controller: bcd_o drives that controller's value_i, and digit_valid_o supports leading-zero blanking.
- One conversion per start request, with a start/busy/done handshake; the result is held until the next conversion completes.

Parameters:
- BIN_WIDTH, 27: width of the binary input.
- NUM_DIGITS, 8: number of BCD digits produced. Must match the display controller's NUM_DIGITS.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  conversion request; sampled only in IDLE.
- bin_i  input  BIN_WIDTH  unsigned binary operand; captured on the accepting edge.
- busy_o  output  1  high while a conversion is in progress.
- done_o  output  1  single-cycle pulse when a new result is presented.
- overflow_o  output  1  last result exceeded 10^NUM_DIGITS-1. Held with bcd_o.
- bcd_o  output  NUM_DIGITS*4  packed BCD result; digit k is bits [4k+3:4k], and digit 0 is least significant. Registered.
- digit_valid_o  output  NUM_DIGITS  bit k is high when digit k or any more-significant digit is nonzero; bit 0 is always high. Registered with bcd_o.

Behaviour:
- Reset (asynchronous, rst_i high, any state):
  - state goes to IDLE.
  - busy_o=0, done_o=0, overflow_o=0, bcd_o=0.
  - digit_valid_o has only bit 0 set.
  - Internal shift register, iteration counter and sticky overflow flag are cleared.
  - Reset during SHIFT aborts the conversion: no done_o pulse is produced, and outputs take their reset values.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start_i=1: capture bin_i into the binary part of the working register, clear the BCD part, clear the iteration counter (width $clog2(BIN_WIDTH+1)) and the sticky overflow flag, then go to SHIFT. busy_o goes high after this edge.
- SHIFT, one iteration per clock:
  - (a) For every BCD digit, if the digit is >=5, add 3 to it. All digits are corrected in parallel and each digit stays 4 bits.
  - (b) Shift the whole {BCD, binary} register left by one bit. The binary MSB enters BCD bit 0.
  - (c) If the bit shifted out of the top digit is 1, set the sticky overflow flag.
  - (d) Increment the counter.
- Completion (on the edge performing iteration BIN_WIDTH):
  - Load bcd_o with the final BCD value. If sticky overflow was set, including by this final iteration, load all nines instead and set overflow_o=1; otherwise overflow_o=0.
  - Update digit_valid_o from the value loaded into bcd_o.
  - Assert done_o for exactly one cycle, deassert busy_o, return to IDLE.
- Latency: done_o is high in the cycle following the BIN_WIDTH-th edge after the accepting edge. Default is 27 cycles. Throughput is one conversion per BIN_WIDTH+1 cycles.
- start_i while busy: ignored, with no queuing. bin_i changes during SHIFT have no effect.
- start_i high in the done_o cycle: state is IDLE, so it is accepted. Back-to-back conversions are legal.
- Held outputs: bcd_o, overflow_o and digit_valid_o change only at completion or reset. They are never partial mid-conversion, so the display never shows intermediate values.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then start with bin_i=0 -> done_o pulses 27 cycles after the accepting edge; bcd_o=0x00000000, overflow_o=0, digit_valid_o=0x01.
2. bin_i=12345678 -> bcd_o=0x12345678, digit_valid_o=0xFF, overflow_o=0. Also bin_i=1000 -> bcd_o=0x00001000, digit_valid_o=0x0F.
3. bin_i=99999999 -> bcd_o=0x99999999, overflow_o=0. Then bin_i=100000000 -> bcd_o=0x99999999, overflow_o=1. Then bin_i=2^27-1 -> overflow_o=1.
4. Start accepted with bin_i=42; pulse start_i again with bin_i=7 at cycle 5 -> exactly one done_o, bcd_o=0x00000042, busy_o high for 27 cycles. Then start asserted during the done_o cycle with bin_i=7 -> second done_o 28 cycles after the first, bcd_o=0x00000007.
5. Start with bin_i=12345678; assert rst_i for 1 cycle at cycle 10 -> busy_o=0 immediately, no done_o, bcd_o=0, digit_valid_o=0x01. A fresh start after reset converts correctly.
6. Randomised bin_i, 1000 conversions -> bcd_o matches the reference decimal conversion (saturated to all nines when overflowing), and bcd_o is stable between done_o pulses.
